// File: rtl/ram_ctrl_pkg.sv
// rtl/ram_ctrl_pkg.sv - shared types and sizing helper for the SRAM request front-end
package ram_ctrl_pkg;

    localparam int W_DATA_DEF  = 8;
    localparam int DEPTH_DEF   = 256;
    localparam int W_ADDR_DEF  = $clog2(DEPTH_DEF);
    localparam int LATENCY_DEF = 1;

    typedef logic [W_ADDR_DEF-1:0] addr_t;
    typedef logic [W_DATA_DEF-1:0] data_t;

    // One slot per read that can be between issue and pop: LATENCY in the pipe plus one queued.
    function automatic int rsp_depth(input int latency);
        return latency + 1;
    endfunction

endpackage

// File: rtl/ram_req_ctrl_if.sv
// rtl/ram_req_ctrl_if.sv - request, response and SRAM port bundle for ram_req_ctrl
interface ram_req_ctrl_if
    import ram_ctrl_pkg::*;
#(
    parameter int W_DATA = W_DATA_DEF,
    parameter int W_ADDR = W_ADDR_DEF
) ();

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [W_ADDR-1:0] req_addr;
    logic [W_DATA-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [W_DATA-1:0] rsp_rdata;
    logic              ram_write_en;
    logic [W_ADDR-1:0] ram_addr;
    logic [W_DATA-1:0] ram_din;
    logic [W_DATA-1:0] ram_dout;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready, ram_dout,
        output req_ready, rsp_valid, rsp_rdata, ram_write_en, ram_addr, ram_din
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready, ram_dout,
        input  req_ready, rsp_valid, rsp_rdata, ram_write_en, ram_addr, ram_din
    );

endinterface

// File: rtl/ram_req_ctrl_resp_fifo.sv
// rtl/ram_req_ctrl_resp_fifo.sv - circular response buffer with occupancy counter
module resp_fifo
    import ram_ctrl_pkg::*;
#(
    parameter int W_DATA = W_DATA_DEF,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [W_DATA-1:0] din,
    input  logic              pop,
    output logic [W_DATA-1:0] dout,
    output logic              empty,
    output logic              full
);

    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);

    logic [W_DATA-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNTW-1:0]   count_q;
    logic              wr, rd;

    // DEPTH is rarely a power of two, so pointers wrap explicitly.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty = (count_q == '0);
    assign full  = (count_q == CNTW'(DEPTH));
    assign dout  = empty ? '0 : mem_q[rd_ptr_q];
    assign wr    = push && !full;
    assign rd    = pop && !empty;

    always_ff @(posedge clk) begin
        if (wr) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (rd) rd_ptr_q <= next_ptr(rd_ptr_q);
            if (wr && !rd)      count_q <= count_q + CNTW'(1);
            else if (rd && !wr) count_q <= count_q - CNTW'(1);
        end
    end

endmodule

// File: rtl/ram_req_ctrl.sv
// rtl/ram_req_ctrl.sv - credit-throttled read/write front-end for a fixed-latency SRAM
module ram_req_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int W_DATA  = W_DATA_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int LATENCY = LATENCY_DEF
) (
    input  logic          clk,
    input  logic          rst,
    ram_req_ctrl_if.slave bus
);

    localparam int W_ADDR    = $clog2(DEPTH);
    localparam int RSP_DEPTH = rsp_depth(LATENCY);
    localparam int CW        = $clog2(RSP_DEPTH + 1);

    logic               accept, rd_accept, push, pop;
    logic               fifo_empty, fifo_full;
    logic [W_ADDR-1:0]  addr_w;
    logic [CW-1:0]      credits_q, credits_d;
    logic [LATENCY-1:0] vld_q, vld_d;

    assign bus.req_ready    = !rst && (credits_q != '0);
    assign accept           = bus.req_valid && bus.req_ready;
    assign rd_accept        = accept && !bus.req_write;
    assign addr_w           = bus.req_addr;
    assign bus.ram_addr     = addr_w;
    assign bus.ram_din      = bus.req_wdata;
    assign bus.ram_write_en = accept && bus.req_write;

    // The top bit of the tag pipe lines up with the cycle ram_dout carries that read's data.
    assign push          = vld_q[LATENCY-1];
    assign bus.rsp_valid = !fifo_empty;
    assign pop           = bus.rsp_valid && bus.rsp_ready;

    always_comb begin
        vld_d     = (vld_q << 1) | LATENCY'(rd_accept);
        credits_d = credits_q;
        if (rd_accept && !pop)      credits_d = credits_q - CW'(1);
        else if (pop && !rd_accept) credits_d = credits_q + CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits_q <= CW'(RSP_DEPTH);
            vld_q     <= '0;
        end else begin
            credits_q <= credits_d;
            vld_q     <= vld_d;
        end
    end

    resp_fifo #(
        .W_DATA (W_DATA),
        .DEPTH  (RSP_DEPTH)
    ) u_resp_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (bus.ram_dout),
        .pop   (pop),
        .dout  (bus.rsp_rdata),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    a_credit_underflow: assert property (@(posedge clk) disable iff (rst)
        !(rd_accept && credits_q == '0));
    a_credit_overflow: assert property (@(posedge clk) disable iff (rst)
        !(pop && !rd_accept && credits_q == CW'(RSP_DEPTH)));
    a_credit_range: assert property (@(posedge clk) disable iff (rst)
        credits_q <= CW'(RSP_DEPTH));
    a_fifo_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && fifo_full));

endmodule

// File: tb/tb_ram_req_ctrl.sv
// tb/tb_ram_req_ctrl.sv - randomized and directed bench for ram_req_ctrl with a queue-based model
module tb_ram_req_ctrl;
    import ram_ctrl_pkg::*;

    localparam int LAT = 2;
    localparam int RSP = LAT + 1;

    typedef struct { int due; logic [7:0] data; } infl_t;
    typedef struct { logic [7:0] data; int cyc; } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_req_ctrl_if #(.W_DATA(8), .W_ADDR(8)) bus ();

    ram_req_ctrl #(.W_DATA(8), .DEPTH(256), .LATENCY(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // SRAM model: two-stage read pipe, write lands at the clock edge.
    data_t sram [256];
    data_t p1, p2;
    always @(posedge clk) begin
        if (bus.ram_write_en) sram[bus.ram_addr] <= bus.ram_din;
        p1 <= sram[bus.ram_addr];
        p2 <= p1;
    end
    assign bus.ram_dout = p2;

    int n_checks = 0;
    int n_fail   = 0;

    data_t m_mem [256];
    infl_t m_infl [$];
    data_t m_fifo [$];
    int    m_credits;
    int    cyc = 0;
    rsp_t  got [$];

    logic obs_ready, obs_acc, obs_rv;
    data_t obs_rdata;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_infl.delete();
        m_fifo.delete();
        m_credits = RSP;
    endtask

    task automatic cycle(input bit v, input bit w, input addr_t a, input data_t d, input bit rr);
        bit    exp_ready, exp_rv, acc;
        data_t rd_val;
        @(negedge clk);
        bus.req_valid = v;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.rsp_ready = rr;
        #1;
        exp_ready = (m_credits != 0);
        exp_rv    = (m_fifo.size() != 0);
        acc       = v && exp_ready;
        check_eq("req_ready", bus.req_ready, exp_ready);
        check_eq("rsp_valid", bus.rsp_valid, exp_rv);
        if (exp_rv) check_eq("rsp_rdata", bus.rsp_rdata, m_fifo[0]);
        check_eq("ram_we", bus.ram_write_en, acc && w);
        check_eq("ram_addr", bus.ram_addr, a);
        check_eq("ram_din", bus.ram_din, d);
        obs_ready = bus.req_ready;
        obs_acc   = v && bus.req_ready;
        obs_rv    = bus.rsp_valid;
        obs_rdata = bus.rsp_rdata;
        if (exp_rv && rr) begin
            rd_val = m_fifo.pop_front();
            got.push_back('{rd_val, cyc});
            m_credits++;
        end
        if (acc && !w) begin
            m_infl.push_back('{cyc + LAT + 1, m_mem[a]});
            m_credits--;
        end
        if (acc && w) m_mem[a] = d;
        while (m_infl.size() != 0 && m_infl[0].due == cyc + 1) begin
            m_fifo.push_back(m_infl[0].data);
            void'(m_infl.pop_front());
        end
        cyc++;
    endtask

    task automatic idle(input bit rr);
        cycle(1'b0, 1'b0, 8'h00, 8'h00, rr);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        rst = 1'b1;
        #1;
        check_eq({tag, "_rv"}, bus.rsp_valid, 1'b0);
        check_eq({tag, "_rdy"}, bus.req_ready, 1'b0);
        check_eq({tag, "_we"}, bus.ram_write_en, 1'b0);
        check_eq({tag, "_rdata"}, bus.rsp_rdata, 8'h00);
        model_clear();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq({tag, "_rdy_rel"}, bus.req_ready, 1'b1);
        check_eq({tag, "_credits"}, dut.credits_q, RSP);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int    k, acc_cnt, ncyc;
        addr_t t3_addr [5];
        bit    v, w, rr;
        addr_t a;

        for (int i = 0; i < 256; i++) begin
            sram[i]  = '0;
            m_mem[i] = '0;
        end
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;
        model_clear();
        do_reset("rst0");

        // Read-after-write latency
        cycle(1'b1, 1'b1, 8'h10, 8'hA5, 1'b0);
        cycle(1'b1, 1'b0, 8'h10, 8'h00, 1'b0);
        k = 0;
        do begin
            idle(1'b0);
            k++;
        end while (!obs_rv && k < 10);
        check_eq("t1_lat", k, 3);
        check_eq("t1_data", obs_rdata, 8'hA5);
        idle(1'b1);

        // Boundary addresses, back-to-back reads
        cycle(1'b1, 1'b1, 8'h00, 8'h11, 1'b1);
        cycle(1'b1, 1'b1, 8'hFF, 8'h22, 1'b1);
        got.delete();
        cycle(1'b1, 1'b0, 8'hFF, 8'h00, 1'b1);
        check_eq("t2_rdy0", obs_ready, 1'b1);
        cycle(1'b1, 1'b0, 8'h00, 8'h00, 1'b1);
        check_eq("t2_rdy1", obs_ready, 1'b1);
        repeat (6) idle(1'b1);
        check_eq("t2_cnt", got.size(), 2);
        while (got.size() < 2) got.push_back('{8'h00, -100});
        check_eq("t2_first", got[0].data, 8'h22);
        check_eq("t2_second", got[1].data, 8'h11);
        check_eq("t2_gap", got[1].cyc - got[0].cyc, 1);

        // Back-pressure: five reads offered, only RSP accepted
        got.delete();
        t3_addr = '{8'h10, 8'h00, 8'hFF, 8'h10, 8'h00};
        acc_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0, t3_addr[i], 8'h00, 1'b0);
            if (obs_acc) acc_cnt++;
        end
        check_eq("t3_accepted", acc_cnt, 3);
        check_eq("t3_rdy_low", obs_ready, 1'b0);
        idle(1'b0);
        idle(1'b1);
        check_eq("t3_rdy_at_pop", obs_ready, 1'b0);
        idle(1'b1);
        check_eq("t3_rdy_after_pop", obs_ready, 1'b1);
        repeat (4) idle(1'b1);
        check_eq("t3_cnt", got.size(), 3);
        while (got.size() < 3) got.push_back('{8'h00, -100});
        check_eq("t3_r0", got[0].data, 8'hA5);
        check_eq("t3_r1", got[1].data, 8'h11);
        check_eq("t3_r2", got[2].data, 8'h22);

        // Read accept coinciding with a pop at credits == 1
        cycle(1'b1, 1'b0, 8'h10, 8'h00, 1'b0);
        cycle(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        repeat (3) idle(1'b0);
        check_eq("t4_cr_before", dut.credits_q, 1);
        cycle(1'b1, 1'b0, 8'hFF, 8'h00, 1'b1);
        check_eq("t4_acc", obs_acc, 1'b1);
        idle(1'b0);
        check_eq("t4_cr_after", dut.credits_q, 1);
        check_eq("t4_rdy", obs_ready, 1'b1);
        repeat (6) idle(1'b1);

        // Reset with two reads in flight and one queued
        cycle(1'b1, 1'b0, 8'h10, 8'h00, 1'b0);
        idle(1'b0);
        cycle(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        cycle(1'b1, 1'b0, 8'hFF, 8'h00, 1'b0);
        check_eq("t5_queued", m_fifo.size(), 1);
        check_eq("t5_inflight", m_infl.size(), 2);
        do_reset("t5");
        got.delete();
        repeat (10) idle(1'b1);
        check_eq("t5_no_stale", got.size(), 0);

        // Random traffic against the model
        acc_cnt = 0;
        ncyc    = 0;
        while (acc_cnt < 1000 && ncyc < 20000) begin
            v  = ($urandom_range(0, 3) != 0);
            w  = $urandom_range(0, 1);
            a  = ($urandom_range(0, 1) != 0) ? addr_t'($urandom_range(0, 7)) : addr_t'($urandom_range(0, 255));
            rr = ($urandom_range(0, 3) != 0);
            cycle(v, w, a, data_t'($urandom), rr);
            if (obs_acc) acc_cnt++;
            ncyc++;
        end
        check_eq("rand_accepted", acc_cnt, 1000);
        repeat (8) idle(1'b1);
        check_eq("rand_drained", bus.rsp_valid, 1'b0);
        check_eq("rand_credits", dut.credits_q, RSP);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
